uart_rx_16b: RTL

//  UART receiver: the receive end of the 16-bit UART link whose transmit FSM sends a word as two 8N1 frames.

---
 rtl/uart_rx_16b.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_16b.sv
// -----------------------------------------------------------------------------
// uart_rx_16b
//   Receive end of the 16-bit UART link. The far end sends each word as
//   WORDBYTES back-to-back frames. The first frame carries the low byte, and
//   each frame is sent LSB first. This block oversamples the line, rebuilds
//   the bytes and presents the complete word with a one-cycle rxDone strobe.
//
// Build option
//   UART_RX_PARITY_EN  When defined, each frame carries an even parity bit
//                      between the data and the stop bit, and a mismatch
//                      raises parityErr. When undefined, frames are 8N1 and
//                      parityErr is tied to 0.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   rx         in   serial line, idle high, asynchronous to clk
//   rxData     out  last complete word (byte0 in the low bits)
//   rxDone     out  one-cycle pulse, rxData just updated
//   rxBusy     out  high whenever the receiver is not in IDLE
//   frameErr   out  one-cycle pulse, stop bit sampled low, word discarded
//   parityErr  out  one-cycle pulse, parity mismatch, word discarded
// -----------------------------------------------------------------------------
module uart_rx_16b #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FRAMEWIDTH   = 8,
  parameter int WORDBYTES    = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rx,
  output logic [FRAMEWIDTH*WORDBYTES-1:0]  rxData,
  output logic                             rxDone,
  output logic                             rxBusy,
  output logic                             frameErr,
  output logic                             parityErr
);

  localparam int WORD_W = FRAMEWIDTH * WORDBYTES;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (FRAMEWIDTH > 1) ? $clog2(FRAMEWIDTH) : 1;
  localparam int BYTE_W = (WORDBYTES > 1) ? $clog2(WORDBYTES) : 1;

  // The start bit is checked at its centre. Each later bit is then exactly
  // one bit period away, so it is also sampled at its centre.
  localparam logic [CNT_W-1:0]  BAUD_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAMEWIDTH - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(WORDBYTES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
`ifdef UART_RX_PARITY_EN
    , PARITY = 3'd6
`endif
  } state_t;

  state_t                  state_q,      state_d;
  logic                    rx_meta_q;
  logic                    rx_s_q;
  logic                    rx_prev_q,    rx_prev_d;
  logic [1:0]              flush_q,      flush_d;
  logic [CNT_W-1:0]        baud_q,       baud_d;
  logic [BIT_W-1:0]        bit_q,        bit_d;
  logic [BYTE_W-1:0]       byte_q,       byte_d;
  logic [FRAMEWIDTH-1:0]   shift_q,      shift_d;
  logic [WORD_W-1:0]       word_q,       word_d;
  logic [WORD_W-1:0]       rx_data_q,    rx_data_d;
  logic                    rx_done_q,    rx_done_d;
  logic                    rx_busy_q,    rx_busy_d;
  logic                    frame_err_q,  frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                    parity_err_q, parity_err_d;
`endif
  logic                    fall;

  // The synchroniser flops reset to 1, which makes the line look idle. If the
  // line is really low when reset is released, the first real sample would
  // look like a falling edge. To prevent this, the edge history ignores the
  // synchroniser until its reset value has been flushed out.
  assign fall = rx_prev_q & ~rx_s_q;

  // NOTE: every *_d gets a default before the case statement, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    flush_d      = {flush_q[0], 1'b1};
    rx_prev_d    = flush_q[1] & rx_s_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    byte_d       = byte_q;
    shift_d      = shift_q;
    word_d       = word_q;
    rx_data_d    = rx_data_q;
    rx_done_d    = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          baud_d  = '0;
          byte_d  = '0;
        end
      end

      WAIT: begin
        if (fall) begin
          state_d = START;
          baud_d  = '0;
        end
      end

      START: begin
        if (baud_q == BAUD_MID) begin
          if (rx_s_q) begin
            // The line went high again before mid-bit, so this was a glitch.
            // Any bytes already collected for this word are kept.
            state_d = (byte_q == '0) ? IDLE : WAIT;
          end else begin
            state_d = DATA;
            baud_d  = '0;
            bit_d   = '0;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {rx_s_q, shift_q[FRAMEWIDTH-1:1]};
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (rx_s_q != ^shift_q) begin
            parity_err_d = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`endif

      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (!rx_s_q) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else begin
            for (int i = 0; i < WORDBYTES; i++) begin
              if (byte_q == BYTE_W'(i)) word_d[i*FRAMEWIDTH +: FRAMEWIDTH] = shift_q;
            end
            if (byte_q == BYTE_LAST) begin
              state_d   = DONE;
              rx_data_d = word_d;
              rx_done_d = 1'b1;
            end else begin
              byte_d  = byte_q + BYTE_W'(1);
              state_d = WAIT;
            end
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rx_busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every flop samples values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b0;
      flush_q      <= '0;
      baud_q       <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      rx_busy_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_prev_q    <= rx_prev_d;
      flush_q      <= flush_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      rx_data_q    <= rx_data_d;
      rx_done_q    <= rx_done_d;
      rx_busy_q    <= rx_busy_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rxData   = rx_data_q;
  assign rxDone   = rx_done_q;
  assign rxBusy   = rx_busy_q;
  assign frameErr = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parityErr = parity_err_q;
`else
  assign parityErr = 1'b0;
`endif

endmodule
